ray_marcher: RTL and testbench

- Sphere-tracing controller; the initiator side of the SDF evaluator's start/done handshake.
- Takes a ray (origin, unit direction) and repeatedly computes p = o + t*d.
- Issues each point to the SDF evaluator, waits for its distance, and advances t by that distance until a hit, MAX_DIST, or MAX_STEPS.
- Sits between the per-pixel ray generator and the shading/framebuffer stage.

---
 rtl/ray_marcher_pkg.sv | 34 +++
 rtl/ray_marcher_if.sv | 32 +++
 rtl/ray_marcher_point_calc.sv | 20 ++
 rtl/ray_marcher.sv | 128 ++++++++++++
 tb/tb_ray_marcher.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ray_marcher_pkg.sv
// Shared types and fixed-point helpers for the sphere-tracing controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ray_marcher_pkg;

  localparam int BITS  = 32;
  localparam int FIXED = 16;

  typedef logic signed [BITS-1:0] fx_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } vec3_t;

  localparam int  MAX_STEPS_DEF = 64;
  localparam fx_t HIT_EPS_DEF   = 32'sd66;
  localparam fx_t MAX_DIST_DEF  = 32'sh0064_0000;

  // Full-width signed product, arithmetic shift back to QFIXED, truncated to BITS.
  function automatic fx_t fx_mul(input fx_t a, input fx_t b);
    logic signed [2*BITS-1:0] w_a;
    logic signed [2*BITS-1:0] w_b;
    logic signed [2*BITS-1:0] w_prod;
    logic signed [2*BITS-1:0] w_shift;
    w_a     = {{BITS{a[BITS-1]}}, a};
    w_b     = {{BITS{b[BITS-1]}}, b};
    w_prod  = w_a * w_b;
    w_shift = w_prod >>> FIXED;
    return w_shift[BITS-1:0];
  endfunction

endpackage

// File: rtl/ray_marcher_if.sv
// Ray-in / SDF-request / result bus around the sphere-tracing controller.
// Latency: n/a (wiring only).
// Backpressure: none; start/done pulses, a new ray is taken only while busy is low.
interface ray_marcher_if;
  import ray_marcher_pkg::*;

  logic       ray_start;
  fx_t        ox, oy, oz;
  fx_t        dx, dy, dz;
  logic       sdf_start;
  fx_t        x, y, z;
  logic       sdf_done;
  fx_t        sdf_out;
  logic       busy;
  logic       ray_done;
  logic       hit;
  fx_t        t_out;
  logic [7:0] steps_out;

  // Controller side.
  modport master (
    input  ray_start, ox, oy, oz, dx, dy, dz, sdf_done, sdf_out,
    output sdf_start, x, y, z, busy, ray_done, hit, t_out, steps_out
  );

  // Ray generator / SDF evaluator / shading side.
  modport slave (
    output ray_start, ox, oy, oz, dx, dy, dz, sdf_done, sdf_out,
    input  sdf_start, x, y, z, busy, ray_done, hit, t_out, steps_out
  );

endinterface

// File: rtl/ray_marcher_point_calc.sv
// Point along a ray: p = o + t*d per axis, QFIXED multiply, wrapping add.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module ray_point_calc
  import ray_marcher_pkg::*;
(
  input  vec3_t i_o,
  input  vec3_t i_d,
  input  fx_t   i_t,
  output vec3_t o_p
);

  // Each axis independently; the sum wraps in two's complement by design.
  always_comb begin
    o_p.x = i_o.x + fx_mul(i_t, i_d.x);
    o_p.y = i_o.y + fx_mul(i_t, i_d.y);
    o_p.z = i_o.z + fx_mul(i_t, i_d.z);
  end

endmodule

// File: rtl/ray_marcher.sv
// Sphere-tracing controller: steps t along a ray by SDF distance until hit, far limit or step limit.
// Latency: 3 cycles per step plus SDF latency; ray_done 2 cycles after the terminating sdf_done.
// Backpressure: ray_start honoured only in IDLE; waits indefinitely for sdf_done.
module ray_marcher
  import ray_marcher_pkg::*;
#(
  parameter int  MAX_STEPS = MAX_STEPS_DEF,
  parameter fx_t HIT_EPS   = HIT_EPS_DEF,
  parameter fx_t MAX_DIST  = MAX_DIST_DEF
) (
  input  logic          clk_in,
  input  logic          rst_in,
  ray_marcher_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;

  localparam logic [7:0] STEP_LIM = 8'(MAX_STEPS);

  state_t     r_state;
  vec3_t      r_o, r_d, r_p;
  fx_t        r_t, r_dist, r_t_out;
  logic [7:0] r_step, r_steps_out;
  logic       r_sdf_start, r_busy, r_ray_done, r_hit;

  vec3_t      w_p;
  fx_t        w_t_next;
  logic [7:0] w_step_next;

  ray_point_calc u_point (
    .i_o (r_o),
    .i_d (r_d),
    .i_t (r_t),
    .o_p (w_p)
  );

  assign w_t_next    = r_t + r_dist;
  assign w_step_next = r_step + 8'd1;

  // Marching FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_o         <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_t         <= '0;
      r_dist      <= '0;
      r_step      <= '0;
      r_t_out     <= '0;
      r_steps_out <= '0;
      r_sdf_start <= 1'b0;
      r_busy      <= 1'b0;
      r_ray_done  <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ray_start) begin
            r_o     <= {bus.ox, bus.oy, bus.oz};
            r_d     <= {bus.dx, bus.dy, bus.dz};
            r_t     <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_p         <= w_p;
          r_sdf_start <= 1'b1;
          r_state     <= S_REQ;
        end
        S_REQ: begin
          r_sdf_start <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.sdf_done) begin
            r_dist  <= bus.sdf_out;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Hit wins over the far limit, which wins over the step limit.
          if (r_dist < HIT_EPS) begin
            r_hit       <= 1'b1;
            r_t_out     <= r_t;
            r_steps_out <= w_step_next;
            r_ray_done  <= 1'b1;
            r_state     <= S_DONE;
          end else if ((w_t_next >= MAX_DIST) || (w_step_next == STEP_LIM)) begin
            r_hit       <= 1'b0;
            r_t_out     <= w_t_next;
            r_steps_out <= w_step_next;
            r_ray_done  <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_t     <= w_t_next;
            r_step  <= w_step_next;
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_ray_done <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_sdf_start <= 1'b0;
          r_ray_done  <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sdf_start = r_sdf_start;
  assign bus.x         = r_p.x;
  assign bus.y         = r_p.y;
  assign bus.z         = r_p.z;
  assign bus.busy      = r_busy;
  assign bus.ray_done  = r_ray_done;
  assign bus.hit       = r_hit;
  assign bus.t_out     = r_t_out;
  assign bus.steps_out = r_steps_out;

endmodule

// File: tb/tb_ray_marcher.sv
// Bench for ray_marcher: behavioural SDF evaluator with programmable latency plus a result scoreboard.
module tb_ray_marcher;
  import ray_marcher_pkg::*;

  typedef struct packed {
    logic       hit;
    fx_t        t;
    logic [7:0] steps;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ray_marcher_if bus ();

  ray_marcher dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_err = 0;
  int    done_cnt = 0;
  int    lat = 1;
  int    mode = 0;
  fx_t   cval = 32'sh0001_0000;
  int    q_cnt = 0;
  vec3_t q1 = '0;
  exp_t  sb_q[$];

  localparam fx_t ONE  = 32'sh0001_0000;
  localparam fx_t NEG5 = -32'sh0005_0000;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // mode 0: plane z=-1 seen from below; mode 1: constant distance.
  function automatic fx_t sdf_model(input vec3_t p);
    fx_t r;
    if (mode == 0) r = -p.z - ONE;
    else           r = cval;
    return r;
  endfunction

  // SDF evaluator: answers each sdf_start after lat cycles, checking the request stays put.
  initial begin
    vec3_t pq;
    bus.sdf_done = 1'b0;
    bus.sdf_out  = '0;
    forever begin
      @(posedge clk); #1;
      bus.sdf_done = 1'b0;
      if (bus.sdf_start) begin
        pq = {bus.x, bus.y, bus.z};
        if (q_cnt == 1) q1 = pq;
        q_cnt++;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (i == 0) chk("sdf_start_width", 64'(bus.sdf_start), 64'd0);
          if (bus.busy) chk("xyz_stable", 64'({bus.x, bus.y, bus.z} != pq), 64'd0);
        end
        bus.sdf_out  = sdf_model(pq);
        bus.sdf_done = 1'b1;
      end
    end
  end

  // Result monitor: every ray_done pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.ray_done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ray_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("hit", 64'(bus.hit), 64'(e.hit));
          chk("t_out", 64'(bus.t_out), 64'(e.t));
          chk("steps_out", 64'(bus.steps_out), 64'(e.steps));
        end
      end
    end
  end

  task automatic rst_checks(input string tag);
    chk({tag, "_sdf_start"}, 64'(bus.sdf_start), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
    chk({tag, "_ray_done"},  64'(bus.ray_done), 64'd0);
    chk({tag, "_hit"},       64'(bus.hit), 64'd0);
    chk({tag, "_t_out"},     64'(bus.t_out), 64'd0);
    chk({tag, "_steps"},     64'(bus.steps_out), 64'd0);
    chk({tag, "_xyz"},       64'({bus.x, bus.y, bus.z} != '0), 64'd0);
  endtask

  task automatic run_ray(input fx_t ox, input fx_t oy, input fx_t oz,
                         input fx_t dx, input fx_t dy, input fx_t dz,
                         input logic eh, input fx_t et, input logic [7:0] es,
                         input bit spam);
    int base;
    bit seen;
    sb_q.push_back('{hit: eh, t: et, steps: es});
    q_cnt = 0;
    base  = done_cnt;
    bus.ox = ox; bus.oy = oy; bus.oz = oz;
    bus.dx = dx; bus.dy = dy; bus.dz = dz;
    bus.ray_start = 1'b1;
    @(posedge clk); #1;
    bus.ray_start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("sdf_start_calc", 64'(bus.sdf_start), 64'd0);
    @(posedge clk); #1;
    chk("sdf_start_req", 64'(bus.sdf_start), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (bus.ray_done || done_cnt != base) begin
        seen = 1'b1;
        bus.ray_start = 1'b0;
      end else begin
        if (spam) begin
          bus.ray_start = (c % 3 == 0);
          bus.ox = 32'sh0123_0000;
        end
        @(posedge clk); #1;
      end
    end
    bus.ray_start = 1'b0;
    bus.ox = ox;
    if (!seen) chk("ray_done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    chk("ray_done_pulse", 64'(bus.ray_done), 64'd0);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t_out_held", 64'(bus.t_out), 64'(et));
    chk("hit_held", 64'(bus.hit), 64'(eh));
  endtask

  initial begin
    int  base;
    int  bz;
    bit  seen;
    bus.ray_start = 1'b0;
    bus.ox = '0; bus.oy = '0; bus.oz = '0;
    bus.dx = '0; bus.dy = '0; bus.dz = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_checks("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plane hit after two evaluations.
    mode = 0; lat = 1;
    run_ray('0, '0, NEG5, '0, '0, ONE, 1'b1, 32'sh0004_0000, 8'd2, 1'b0);

    // Constant 1.0: step limit ends the ray at t=64.0.
    mode = 1; cval = ONE;
    run_ray('0, '0, '0, ONE, '0, '0, 1'b0, 32'sh0040_0000, 8'd64, 1'b0);

    // Constant 10.0: lands exactly on the far limit.
    cval = 32'sh000A_0000;
    run_ray('0, '0, '0, ONE, '0, '0, 1'b0, 32'sh0064_0000, 8'd10, 1'b0);

    // Negative distance, and the hit threshold on either side.
    cval = 32'shFFFF_8000;
    run_ray('0, '0, '0, ONE, '0, '0, 1'b1, '0, 8'd1, 1'b0);
    cval = 32'sd65;
    run_ray('0, '0, '0, ONE, '0, '0, 1'b1, '0, 8'd1, 1'b0);
    cval = 32'sd66;
    run_ray('0, '0, '0, ONE, '0, '0, 1'b0, 32'sd4224, 8'd64, 1'b0);

    // Oblique direction: second query point at t=2.5 exercises the multiply on every axis.
    cval = 32'sh0002_8000;
    run_ray(32'sh0001_0000, 32'sh0002_0000, 32'sh0003_0000,
            32'sh0000_9999, 32'shFFFF_3334, '0, 1'b0, 32'sh0064_0000, 8'd40, 1'b0);
    chk("q1_x", 64'(q1.x), 64'(32'sh0002_7FFE));
    chk("q1_y", 64'(q1.y), 64'(32'sh0000_0002));
    chk("q1_z", 64'(q1.z), 64'(32'sh0003_0000));

    // Slow evaluator with ray_start hammered while busy.
    mode = 0; lat = 37;
    run_ray('0, '0, NEG5, '0, '0, ONE, 1'b1, 32'sh0004_0000, 8'd2, 1'b1);

    // Reset during WAIT abandons the ray; the late sdf_done must be ignored.
    bus.ox = '0; bus.oy = '0; bus.oz = NEG5;
    bus.dx = '0; bus.dy = '0; bus.dz = ONE;
    bus.ray_start = 1'b1;
    @(posedge clk); #1;
    bus.ray_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.sdf_start) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_req_seen", 64'(seen), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_checks("abort");
    rst_n = 1'b1;
    base = done_cnt;
    bz = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.busy) bz++;
    end
    chk("abort_no_done", 64'(done_cnt - base), 64'd0);
    chk("abort_stays_idle", 64'(bz), 64'd0);

    lat = 1;
    run_ray('0, '0, NEG5, '0, '0, ONE, 1'b1, 32'sh0004_0000, 8'd2, 1'b0);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
